// File: rtl/risc8_pkg.sv
// Shared types and defaults for the risc8 memory subsystem.
//   arb_state_t : memory port arbiter FSM states
//   owner_t     : bus owner encoding, also driven on the arbiter's owner debug port
//   AW_DEF/DW_DEF : default memory address/data widths
//   pick_winner : fixed-priority choice between the CPU and the loader
package risc8_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  // ldr_first selects loader-over-CPU ordering; otherwise the CPU goes first.
  function automatic owner_t pick_winner(input logic cpu_req, input logic ldr_req,
                                         input logic ldr_first);
    owner_t w;
    w = OWN_NONE;
    if (ldr_first) begin
      if (ldr_req)      w = OWN_LDR;
      else if (cpu_req) w = OWN_CPU;
    end else begin
      if (cpu_req)      w = OWN_CPU;
      else if (ldr_req) w = OWN_LDR;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Saturating count of consecutive CPU grants made while the loader is waiting.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   inc      : CPU grant issued with the loader requesting
//   clr      : loader grant issued, or loader not requesting (wins over inc)
//   at_max   : count has reached MAX
module mem_arb_burst_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] count;

  assign at_max = (count == CW'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port program/data memory between the CPU controller
// and the program loader/debug port. One outstanding access at a time; reads
// return data with a one-cycle rvalid pulse on the requester that issued them.
// Optional feature: define ARB_STARVE_GUARD_EN to force a loader grant after
// MAX_CPU_BURST consecutive CPU grants while the loader waits; without it the
// priority is strict.
//   clk, rst                        : clock, synchronous active-high reset
//   cpu_halt                        : loader has priority while high
//   cpu_req/we/addr/wdata           : CPU command, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata  : CPU grant pulse, read-valid pulse, read data
//   ldr_*                           : same set for the loader
//   mem_addr, mem_wdata, mem_rd, mem_we : registered memory command
//   mem_rdata                       : synchronous memory read data (cycle after mem_rd)
//   owner                           : current bus owner (0 none, 1 CPU, 2 loader)
module mem_port_arbiter
  import risc8_pkg::*;
#(
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_halt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  arb_state_t    state;
  owner_t        own_q;
  owner_t        win;
  logic          arb_en;
  logic          guard_hit;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ldr_rdata_q;

  // Arbitration runs in IDLE and also in RESP, overlapping the read return.
  assign arb_en = (state == IDLE) || (state == RESP);
  assign win    = arb_en ? pick_winner(cpu_req, ldr_req, cpu_halt || guard_hit) : OWN_NONE;

`ifdef ARB_STARVE_GUARD_EN
  logic burst_full;

  mem_arb_burst_cnt #(
    .MAX(MAX_CPU_BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   ((win == OWN_CPU) && ldr_req),
    .clr   ((win == OWN_LDR) || !ldr_req),
    .at_max(burst_full)
  );

  assign guard_hit = burst_full && ldr_req;
`else
  assign guard_hit = 1'b0;
`endif

  always_comb begin
    sel_we    = ldr_we;
    sel_addr  = ldr_addr;
    sel_wdata = ldr_wdata;
    if (win == OWN_CPU) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  // Read data arrives combinationally in RESP (synchronous memory, one cycle
  // after mem_rd); rst masks it so a read caught by reset never reports valid.
  assign cpu_rvalid = (state == RESP) && (own_q == OWN_CPU) && !rst;
  assign ldr_rvalid = (state == RESP) && (own_q == OWN_LDR) && !rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_rdata_q;
  assign owner      = own_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      own_q       <= OWN_NONE;
      cpu_gnt     <= 1'b0;
      ldr_gnt     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      cpu_gnt <= (win == OWN_CPU);
      ldr_gnt <= (win == OWN_LDR);
      mem_rd  <= 1'b0;
      mem_we  <= 1'b0;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ldr_rvalid) ldr_rdata_q <= mem_rdata;
      unique case (state)
        IDLE, RESP: begin
          if (win != OWN_NONE) begin
            state     <= ACCESS;
            own_q     <= win;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_rd    <= !sel_we;
          end else begin
            state <= IDLE;
            own_q <= OWN_NONE;
          end
        end
        ACCESS: begin
          if (mem_we) begin
            state <= IDLE;
            own_q <= OWN_NONE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
          own_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
